// File: rtl/periph_rx_pkg.sv
// -----------------------------------------------------------------------------
// periph_rx_pkg
// Shared types for the peripheral-side receive buffer:
//   rx_state_t : handshake FSM states (IDLE, ACK_HI, WAIT_LOW)
//   CHAN_W     : width of the channel tag
//   RX_DATA_W  : default width of the dado word
//   rx_entry_t : one buffered word {chan, data} at the default width
// -----------------------------------------------------------------------------
package periph_rx_pkg;

    localparam int CHAN_W    = 1;
    localparam int RX_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK_HI   = 2'd1,
        WAIT_LOW = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [CHAN_W-1:0]    chan;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/periph_rx_fifo.sv
// -----------------------------------------------------------------------------
// periph_rx_fifo
// Synchronous DEPTH-entry FIFO of entry_t words with a first-word-fall-through
// head. Pushes while full and pops while empty are ignored.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   push, push_entry    write request and word
//   pop                 read request (advances the head)
//   head_valid, head    head word; head reads as zero while empty
//   count               occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module periph_rx_fifo
    import periph_rx_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = rx_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output logic                       head_valid,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && (cnt != CNT_W'(DEPTH));
    assign do_pop  = pop  && (cnt != '0);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible
    // because the head is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head_valid = (cnt != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;
    assign count      = cnt;

endmodule

// File: rtl/periph_rx_buffer.sv
// -----------------------------------------------------------------------------
// periph_rx_buffer
// Peripheral-side receiver for the processor->peripheral bus. Completes the
// two-channel 4-phase send/ack handshake, captures {channel, dado} into a
// FIFO and offers the words on a valid/ready read port.
// Ports:
//   clk, rst       peripheral clock, synchronous active-low reset
//   dado           data word, stable while the matching send bit is high
//   send[1:0]      per-channel request
//   ack[1:0]       per-channel acknowledge (registered, at most one bit high)
//   rd_valid       FIFO head valid
//   rd_ready       consumer accepts the head
//   rd_data        head data (zero while empty)
//   rd_chan        head channel tag (zero while empty)
//   count          FIFO occupancy
// Configuration:
//   PERIPH_RX_SYNC_EN  when defined, each send bit passes through a 2-flop
//                      synchronizer; when undefined send is used directly and
//                      must come from the clk domain.
// -----------------------------------------------------------------------------
module periph_rx_buffer
    import periph_rx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      dado,
    input  logic [1:0]             send,
    output logic [1:0]             ack,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_chan,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [1:0] send_s;

`ifdef PERIPH_RX_SYNC_EN
    logic [1:0] sync_q1;
    logic [1:0] sync_q2;

    // dado is not synchronized: it is held stable for the whole handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 2'b00;
            sync_q2 <= 2'b00;
        end else begin
            sync_q1 <= send;
            sync_q2 <= sync_q1;
        end
    end
    assign send_s = sync_q2;
`else
    assign send_s = send;
`endif

    rx_state_t  state;
    rx_state_t  state_nxt;
    logic       cur;
    logic       last;
    logic       sel;
    logic       space;
    logic [1:0] eligible;
    logic       push;
    logic [1:0] ack_nxt;
    entry_t     push_entry;
    entry_t     head;

    assign space    = (count < CNT_W'(DEPTH));
    assign eligible = send_s & {2{space}};

    // On a tie serve the channel not served last; otherwise the only
    // eligible one (sel is a don't-care when neither is eligible).
    assign sel = (eligible == 2'b11) ? ~last : ~eligible[0];

    // State register; cur, last and ack are updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cur   <= 1'b0;
            last  <= 1'b1;
            ack   <= 2'b00;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
            if (push) begin
                cur  <= sel;
                last <= sel;
            end
        end
    end

    // Next-state logic.
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|eligible)   state_nxt = ACK_HI;
            ACK_HI:                    state_nxt = WAIT_LOW;
            WAIT_LOW: if (!send_s[cur]) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs: capture strobe and the acknowledge to be registered. The ack
    // follows the channel that will be current after this edge.
    always_comb begin
        push    = (state == IDLE) && (|eligible);
        ack_nxt = 2'b00;
        if (state_nxt != IDLE) begin
            ack_nxt = push ? (2'b01 << sel) : (2'b01 << cur);
        end
    end

    assign push_entry.chan = sel;
    assign push_entry.data = dado;

    periph_rx_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (rd_valid && rd_ready),
        .head_valid (rd_valid),
        .head       (head),
        .count      (count)
    );

    assign rd_data = head.data;
    assign rd_chan = head.chan;

endmodule

// File: tb/tb_periph_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_periph_rx_buffer
// Self-checking bench for periph_rx_buffer. A processor-side driver performs
// 4-phase handshakes; every sent word is pushed onto a scoreboard queue and
// popped/compared when the consumer side accepts it. Works with and without
// PERIPH_RX_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_periph_rx_buffer;
    import periph_rx_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
`ifdef PERIPH_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Edges from the first edge sampling send low until ack falls, when send
    // is dropped right after the capture edge (ACK_HI forces one extra cycle).
    localparam int DROP_LAT = (SYNC_LAT == 0) ? 1 : SYNC_LAT;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      dado;
    logic [1:0]             send;
    logic [1:0]             ack;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_chan;
    logic [$clog2(DEPTH):0] count;

    int        n_checks = 0;
    int        n_pass   = 0;
    rx_entry_t sb [$];
    rx_entry_t mon_e;

    periph_rx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .dado     (dado),
        .send     (send),
        .ack      (ack),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_chan  (rd_chan),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int c, input logic v, input string tag);
        int n = 0;
        while (ack[c] !== v && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(ack[c]), 32'(v));
    endtask

    task automatic send_word(input int c, input logic [15:0] d);
        dado    = d;
        send[c] = 1'b1;
        sb.push_back(rx_entry_t'{chan: 1'(c), data: d});
        wait_ack(c, 1'b1, "send_ack_rise");
        send[c] = 1'b0;
        wait_ack(c, 1'b0, "send_ack_fall");
    endtask

    task automatic drain();
        int n = 0;
        rd_ready = 1'b1;
        while (count != 0 && n < 50) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("drain_empty", 32'(count), 0);
    endtask

    // Consumer-side scoreboard: compare just before the edge that pops.
    always @(negedge clk) begin
        if (rst && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                check("rd_chan", 32'(rd_chan), 32'(mon_e.chan));
                check("rd_data", 32'(rd_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; send = 2'b00; dado = '0; rd_ready = 1'b0;
        tick();
        tick();
        check("rst_ack",      32'(ack),      0);
        check("rst_count",    32'(count),    0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data",  32'(rd_data),  0);
        check("rst_rd_chan",  32'(rd_chan),  0);
        rst = 1'b1;
        tick();

        // Single word with exact capture and release latency.
        dado = 16'hA5C3;
        send = 2'b01;
        sb.push_back(rx_entry_t'{chan: 1'b0, data: 16'hA5C3});
        for (int i = 0; i <= SYNC_LAT; i++) begin
            tick();
            check(i < SYNC_LAT ? "s1_ack_early" : "s1_ack_rise", 32'(ack),
                  i < SYNC_LAT ? 32'h0 : 32'h1);
        end
        check("s1_rd_valid", 32'(rd_valid), 1);
        check("s1_rd_data",  32'(rd_data),  32'hA5C3);
        check("s1_rd_chan",  32'(rd_chan),  0);
        check("s1_count",    32'(count),    1);
        send = 2'b00;
        for (int i = 0; i <= DROP_LAT; i++) begin
            tick();
            check("s1_ack_fall", 32'(ack), (i < DROP_LAT) ? 32'h1 : 32'h0);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("s1_empty_valid", 32'(rd_valid), 0);
        check("s1_empty_data",  32'(rd_data),  0);
        check("s1_empty_chan",  32'(rd_chan),  0);
        check("s1_empty_count", 32'(count),    0);

        // Simultaneous requests from reset: channel 0 first, then 1.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dado = 16'h1234;
        send = 2'b11;
        sb.push_back(rx_entry_t'{chan: 1'b0, data: 16'h1234});
        sb.push_back(rx_entry_t'{chan: 1'b1, data: 16'h1234});
        n = 0;
        while (ack == 2'b00 && n < 50) begin
            tick();
            check("s2_ack_onehot", 32'(ack == 2'b11), 0);
            n++;
        end
        check("s2_first", 32'(ack), 32'h1);
        send[0] = 1'b0;
        n = 0;
        while (ack !== 2'b10 && n < 50) begin
            tick();
            check("s2_ack_onehot", 32'(ack == 2'b11), 0);
            n++;
        end
        check("s2_second",    32'(ack),     32'h2);
        check("s2_head_chan", 32'(rd_chan), 0);
        check("s2_count",     32'(count),   2);
        send[1] = 1'b0;
        wait_ack(1, 1'b0, "s2_ack_fall");
        drain();

        // Full FIFO stalls the fifth word until one pop frees a slot.
        for (int i = 0; i < 4; i++) send_word(0, 16'h1000 + 16'(i));
        check("s3_full_count", 32'(count), 4);
        dado = 16'h5555;
        send = 2'b01;
        sb.push_back(rx_entry_t'{chan: 1'b0, data: 16'h5555});
        repeat (SYNC_LAT + 4) tick();
        check("s3_no_ack",  32'(ack),   0);
        check("s3_count_4", 32'(count), 4);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("s3_after_pop", 32'(count), 3);
        wait_ack(0, 1'b1, "s3_late_ack");
        check("s3_refill", 32'(count), 4);
        send = 2'b00;
        wait_ack(0, 1'b0, "s3_ack_fall");
        drain();

        // Push and pop on the same edge at count 2, across pointer wrap.
        send_word(1, 16'h2000);
        send_word(1, 16'h2001);
        check("s4_count_2", 32'(count), 2);
        for (int i = 0; i < 4; i++) begin
            dado = 16'h2100 + 16'(i);
            send = 2'b10;
            sb.push_back(rx_entry_t'{chan: 1'b1, data: 16'h2100 + 16'(i)});
            repeat (SYNC_LAT) tick();
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            check("s4_ack",   32'(ack),   32'h2);
            check("s4_count", 32'(count), 2);
            send = 2'b00;
            wait_ack(1, 1'b0, "s4_ack_fall");
        end
        drain();

        // Reset while in WAIT_LOW with send[1] still high: word is recaptured.
        dado = 16'hBEEF;
        send = 2'b10;
        sb.push_back(rx_entry_t'{chan: 1'b1, data: 16'hBEEF});
        wait_ack(1, 1'b1, "s5_ack_rise");
        tick();
        rst = 1'b0;
        tick();
        check("s5_rst_ack",   32'(ack),   0);
        check("s5_rst_count", 32'(count), 0);
        rst = 1'b1;
        sb.delete();
        sb.push_back(rx_entry_t'{chan: 1'b1, data: 16'hBEEF});
        wait_ack(1, 1'b1, "s5_recapture");
        check("s5_count_1", 32'(count), 1);
        send = 2'b00;
        wait_ack(1, 1'b0, "s5_ack_fall");
        drain();

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
